truth_table_extractor: RTL and testbench
========================================

// Module: truth_table_extractor
// PURPOSE
//  Recovers the 16-bit truth-table ID of a 4-input, 1-output logic netlist by sweeping all input rows.
//  Drives in1..in4 into the netlist under test, waits a settle window, samples out, and assembles the hex ID.
//  Optionally compares the result against an expected ID such as 16'h0068.
//  Sits beside synthesized gate netlists in self-check benches and on-chip characterization harnesses.
// PARAMETERS
//  SETTLE_CYCLES  4  clock cycles inputs are held before out is sampled; legal range >=1
//  CNT_W          8  settle counter width; must satisfy 2**CNT_W > SETTLE_CYCLES
// PORTS
//  clk       in   1   rising-edge clock
//  rst_n     in   1   asynchronous active-low reset
//  start     in   1   request a sweep; accepted only in IDLE
//  abort     in   1   cancel a running sweep
//  exp_tt    in   16  expected truth-table ID; captured when start is accepted
//  out       in   1   output of the netlist under test; same clock domain, combinational
//  in1       out  1   netlist input, row index bit 3 (MSB)
//  in2       out  1   netlist input, row index bit 2
//  in3       out  1   netlist input, row index bit 1
//  in4       out  1   netlist input, row index bit 0 (LSB)
//  busy      out  1   high from the cycle after start is accepted until DONE completes
//  done      out  1   one-cycle pulse when tt is final
//  tt        out  16  extracted truth-table ID
//  tt_valid  out  1   tt holds a complete sweep result
//  match     out  1   tt == captured exp_tt; meaningful only while tt_valid=1
//  unstable  out  1   out changed between the last settle cycle and the sample cycle on some row
// BEHAVIOUR
//  Reset: every output goes to 0 asynchronously (in1..in4, busy, done, tt, tt_valid, match, unstable).
//   The FSM returns to IDLE, row=0, cnt=0. A reset during a sweep discards all progress.
//  Row encoding: row r = {in1,in2,in3,in4}. out sampled at row r is written to tt[15-r].
//   Row 0 therefore lands in the MSB, so tt reads as the netlist's hex ID.
//  FSM states: IDLE, SETTLE, SAMPLE, DONE.
//  IDLE: in1..in4=0, busy=0.
//   On start=1 the block clears tt, tt_valid, match and unstable; sets row=0 and cnt=0;
//   captures exp_tt; goes to SETTLE.
//  SETTLE: busy=1; in1..in4 show row. cnt increments each cycle.
//   On cnt==SETTLE_CYCLES-1 the block registers out into last_out and goes to SAMPLE.
//  SAMPLE: tt[15-row] <= out. If out != last_out, unstable <= 1 (sticky until the next start).
//   row<15: row <= row+1, cnt <= 0, go to SETTLE. row==15: go to DONE.
//  DONE: done=1 for exactly one cycle, tt_valid <= 1, match <= (final tt == exp_tt), busy=0. Next state IDLE.
//  Latency: done asserts 16*(SETTLE_CYCLES+1)+1 cycles after the start-accept edge (81 for the default).
//  start while busy: ignored; no restart, and exp_tt is not re-captured.
//  abort: wins over every other event in SETTLE and SAMPLE. Next state IDLE with in1..in4=0 and tt_valid=0.
//   tt keeps its partial contents, no done pulse is issued, and abort in IDLE or DONE has no effect.
//  start and abort in the same IDLE cycle: start wins. abort is checked only from the following cycle.
//  in1..in4 change only on the SAMPLE->SETTLE edge, so each row is held for exactly SETTLE_CYCLES+1 cycles.
//  tt, tt_valid and match hold their values in IDLE until the next accepted start or a reset.
// TESTING
//  1 Model the netlist as out = in1 & (exactly one of in2,in3,in4); start, exp_tt=16'h0068
//    -> done at cycle 81, tt=16'h0068, tt_valid=1, match=1, unstable=0.
//  2 out tied to 1, exp_tt=16'h0000 -> tt=16'hFFFF, match=0; tied to 0 -> tt=16'h0000.
//  3 out=in4, SETTLE_CYCLES=1 -> tt=16'h5555, done at cycle 33; out=in1 -> tt=16'h00FF.
//  4 abort in cycle 40 -> busy drops next cycle, no done, tt_valid=0, in1..in4=0;
//    a fresh start then yields the correct tt.
//  5 Pulse start every cycle mid-sweep -> sweep continues, done exactly once at cycle 81.
//    rst_n low at cycle 30 -> all outputs 0 immediately.
//  6 Model whose out toggles on the SAMPLE cycle of row 7 -> unstable=1 at done;
//    the next clean sweep clears it.

Source files
------------

// File: rtl/truth_table_extractor.sv
// truth_table_extractor
//   Sweeps all 16 input rows of a 4-input, 1-output netlist and assembles the
//   netlist's 16-bit truth-table ID. Row r = {in1,in2,in3,in4}. The out value
//   sampled at row r lands in tt[15-r], so tt reads as the netlist's hex ID.
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   start         request a sweep (accepted only in IDLE)
//   abort         cancel a running sweep (SETTLE/SAMPLE only)
//   exp_tt[15:0]  expected ID, captured when start is accepted
//   out           netlist output (combinational, same clock domain)
//   in1..in4      netlist inputs, in1 = row MSB
//   busy          sweep in progress
//   done          one-cycle pulse when tt is final
//   tt[15:0]      extracted truth-table ID
//   tt_valid      tt holds a complete sweep result
//   match         tt equals the captured exp_tt (meaningful with tt_valid)
//   unstable      out moved between the last settle cycle and the sample cycle
module truth_table_extractor #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] exp_tt,
  input  logic        out,
  output logic        in1,
  output logic        in2,
  output logic        in3,
  output logic        in4,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic        tt_valid,
  output logic        match,
  output logic        unstable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       ROW_LAST = 4'd15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [3:0]       row;
  logic [CNT_W-1:0] cnt;
  logic             last_out;
  logic [15:0]      exp_q;
  logic             settle_end_c;

  assign settle_end_c = (cnt == CNT_LAST);

  // Row register drives the netlist directly; it is zero whenever no sweep runs.
  assign {in1, in2, in3, in4} = row;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic; abort takes priority inside a sweep.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = SETTLE;
      SETTLE: begin
        if (abort)             state_n = IDLE;
        else if (settle_end_c) state_n = SAMPLE;
      end
      SAMPLE: begin
        if (abort)                 state_n = IDLE;
        else if (row == ROW_LAST)  state_n = DONE;
        else                       state_n = SETTLE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row      <= 4'd0;
      cnt      <= '0;
      last_out <= 1'b0;
      exp_q    <= 16'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tt       <= 16'd0;
      tt_valid <= 1'b0;
      match    <= 1'b0;
      unstable <= 1'b0;
    end else begin
      busy <= (state_n == SETTLE) || (state_n == SAMPLE);
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            tt       <= 16'd0;
            tt_valid <= 1'b0;
            match    <= 1'b0;
            unstable <= 1'b0;
            row      <= 4'd0;
            cnt      <= '0;
            exp_q    <= exp_tt;
          end
        end
        SETTLE: begin
          if (abort) begin
            row      <= 4'd0;
            cnt      <= '0;
            tt_valid <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (settle_end_c) last_out <= out;
          end
        end
        SAMPLE: begin
          if (abort) begin
            row      <= 4'd0;
            cnt      <= '0;
            tt_valid <= 1'b0;
          end else begin
            tt[ROW_LAST - row] <= out;
            if (out != last_out) unstable <= 1'b1;
            cnt <= '0;
            // Row returns to zero after the last sample so the inputs idle low.
            if (row == ROW_LAST) row <= 4'd0;
            else                 row <= row + 4'd1;
          end
        end
        DONE: begin
          tt_valid <= 1'b1;
          match    <= (tt == exp_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_extractor.sv
module tb_truth_table_extractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default settle window.
  logic        start_a = 1'b0, abort_a = 1'b0, out_a;
  logic [15:0] exp_a = 16'd0;
  logic        a_in1, a_in2, a_in3, a_in4, busy_a, done_a, ttv_a, match_a, unst_a;
  logic [15:0] tt_a;

  // Instance B: single-cycle settle window.
  logic        start_b = 1'b0, abort_b = 1'b0, out_b;
  logic [15:0] exp_b = 16'd0;
  logic        b_in1, b_in2, b_in3, b_in4, busy_b, done_b, ttv_b, match_b, unst_b;
  logic [15:0] tt_b;

  truth_table_extractor #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .exp_tt(exp_a), .out(out_a),
    .in1(a_in1), .in2(a_in2), .in3(a_in3), .in4(a_in4),
    .busy(busy_a), .done(done_a), .tt(tt_a), .tt_valid(ttv_a),
    .match(match_a), .unstable(unst_a)
  );

  truth_table_extractor #(.SETTLE_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .exp_tt(exp_b), .out(out_b),
    .in1(b_in1), .in2(b_in2), .in3(b_in3), .in4(b_in4),
    .busy(busy_b), .done(done_b), .tt(tt_b), .tt_valid(ttv_b),
    .match(match_b), .unstable(unst_b)
  );

  // Netlist models: 0 = in1 & exactly-one(in2,in3,in4), 1 = const 1,
  // 2 = const 0, 3 = in4, 4 = in1, otherwise an arbitrary lookup table.
  function automatic logic netlist(input int kind, input logic [15:0] lut,
                                   input logic [3:0] r);
    case (kind)
      0: return r[3] && ($countones(r[2:0]) == 1);
      1: return 1'b1;
      2: return 1'b0;
      3: return r[0];
      4: return r[3];
      default: return lut[4'd15 - r];
    endcase
  endfunction

  // Expected ID: evaluate the netlist model on every row.
  function automatic logic [15:0] ref_tt(input int kind, input logic [15:0] lut);
    logic [15:0] v;
    v = 16'd0;
    for (int r = 0; r < 16; r++) v[15 - r] = netlist(kind, lut, 4'(r));
    return v;
  endfunction

  int          kind_a = 0, kind_b = 3;
  logic [15:0] lut_a = 16'd0, lut_b = 16'd0;
  bit          glitch_en = 1'b0;
  int          cyc = 0;

  // Glitch window is the row-7 sample cycle (between edges 39 and 40 after accept).
  always_comb out_a = netlist(kind_a, lut_a, {a_in1, a_in2, a_in3, a_in4})
                      ^ (glitch_en && (cyc == 39));
  always_comb out_b = netlist(kind_b, lut_b, {b_in1, b_in2, b_in3, b_in4});

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts a sweep and counts cycles from the accept edge to the done pulse.
  task automatic run_sweep(input bit which, input logic [15:0] e, input bit pulse,
                           output int lat);
    if (!which) begin start_a = 1'b1; exp_a = e; end
    else        begin start_b = 1'b1; exp_b = e; end
    cyc = 0;
    tick;
    start_a = 1'b0;
    start_b = 1'b0;
    lat = -1;
    for (int i = 1; i <= 300; i++) begin
      if (pulse) begin start_a = 1'b1; exp_a = 16'($urandom); end
      tick;
      cyc = i;
      if ((which ? done_b : done_a) === 1'b1) begin lat = i; break; end
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic check_result(input string tag, input bit which, input int lat,
                              input int lat_exp, input logic [15:0] tt_exp,
                              input bit m_exp, input bit u_exp);
    logic [3:0] ins;
    check({tag, " latency"}, 32'(lat), 32'(lat_exp));
    check({tag, " tt"}, {16'd0, which ? tt_b : tt_a}, {16'd0, tt_exp});
    check({tag, " tt_valid"}, {31'd0, which ? ttv_b : ttv_a}, 32'd1);
    check({tag, " match"}, {31'd0, which ? match_b : match_a}, {31'd0, m_exp});
    check({tag, " unstable"}, {31'd0, which ? unst_b : unst_a}, {31'd0, u_exp});
    check({tag, " busy at done"}, {31'd0, which ? busy_b : busy_a}, 32'd0);
    ins = which ? {b_in1, b_in2, b_in3, b_in4} : {a_in1, a_in2, a_in3, a_in4};
    check({tag, " inputs idle"}, {28'd0, ins}, 32'd0);
    tick;
    check({tag, " done one cycle"}, {31'd0, which ? done_b : done_a}, 32'd0);
  endtask

  typedef struct {
    bit          which;
    int          kind;
    logic [15:0] exp_in;
    logic [15:0] tt_exp;
    bit          match_exp;
    int          lat_exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int          lat;
    bit          seen;
    logic [15:0] lut, e, r;

    vecs[0] = '{1'b0, 0, 16'h0068, 16'h0068, 1'b1, 81};
    vecs[1] = '{1'b0, 1, 16'h0000, 16'hFFFF, 1'b0, 81};
    vecs[2] = '{1'b0, 2, 16'h0000, 16'h0000, 1'b1, 81};
    vecs[3] = '{1'b1, 3, 16'h5555, 16'h5555, 1'b1, 33};
    vecs[4] = '{1'b1, 4, 16'h0000, 16'h00FF, 1'b0, 33};

    // Reset state.
    tick; tick;
    check("reset tt", {16'd0, tt_a}, 32'd0);
    check("reset flags", {26'd0, busy_a, done_a, ttv_a, match_a, unst_a, 1'b0}, 32'd0);
    check("reset inputs", {28'd0, a_in1, a_in2, a_in3, a_in4}, 32'd0);
    rst_n = 1'b1;
    tick;

    // Fixed netlists.
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].which) kind_b = vecs[i].kind;
      else               kind_a = vecs[i].kind;
      run_sweep(vecs[i].which, vecs[i].exp_in, 1'b0, lat);
      check_result($sformatf("vec%0d", i), vecs[i].which, lat, vecs[i].lat_exp,
                   vecs[i].tt_exp, vecs[i].match_exp, 1'b0);
    end

    // Abort in IDLE leaves the previous result intact.
    abort_a = 1'b1; tick; abort_a = 1'b0;
    check("idle abort tt_valid", {31'd0, ttv_a}, 32'd1);
    check("idle abort tt", {16'd0, tt_a}, 32'h0000);

    // Random netlists against the row-by-row model.
    for (int i = 0; i < 6; i++) begin
      lut = 16'($urandom);
      e = ($urandom_range(0, 1) == 1) ? lut : 16'($urandom);
      kind_a = 5; lut_a = lut;
      r = ref_tt(5, lut);
      run_sweep(1'b0, e, 1'b0, lat);
      check_result($sformatf("rand%0d", i), 1'b0, lat, 81, r, r == e, 1'b0);
    end

    // Abort mid-sweep at cycle 40: rows 0..6 captured, row 7 sample skipped.
    lut = 16'($urandom) | 16'h8000;
    kind_a = 5; lut_a = lut;
    start_a = 1'b1; exp_a = lut; tick; start_a = 1'b0;
    for (int i = 1; i < 40; i++) tick;
    check("abort busy before", {31'd0, busy_a}, 32'd1);
    abort_a = 1'b1; tick; abort_a = 1'b0;
    check("abort busy", {31'd0, busy_a}, 32'd0);
    check("abort inputs", {28'd0, a_in1, a_in2, a_in3, a_in4}, 32'd0);
    check("abort tt_valid", {31'd0, ttv_a}, 32'd0);
    check("abort partial tt", {16'd0, tt_a}, {16'd0, ref_tt(5, lut) & 16'hFE00});
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin tick; if (done_a === 1'b1) seen = 1'b1; end
    check("abort no done", {31'd0, seen}, 32'd0);
    run_sweep(1'b0, lut, 1'b0, lat);
    check_result("after abort", 1'b0, lat, 81, ref_tt(5, lut), 1'b1, 1'b0);

    // Start pulsed every cycle mid-sweep is ignored, exp_tt not re-captured.
    kind_a = 0;
    run_sweep(1'b0, 16'h0068, 1'b1, lat);
    check_result("start spam", 1'b0, lat, 81, 16'h0068, 1'b1, 1'b0);

    // Glitch on the row-7 sample cycle, then a clean sweep clears unstable.
    glitch_en = 1'b1;
    run_sweep(1'b0, 16'h0068, 1'b0, lat);
    glitch_en = 1'b0;
    check_result("glitch", 1'b0, lat, 81, 16'h0168, 1'b0, 1'b1);
    run_sweep(1'b0, 16'h0068, 1'b0, lat);
    check_result("clean", 1'b0, lat, 81, 16'h0068, 1'b1, 1'b0);

    // Reset mid-sweep at cycle 30 clears outputs without a clock edge.
    kind_a = 1;
    start_a = 1'b1; exp_a = 16'hFFFF; tick; start_a = 1'b0;
    for (int i = 1; i <= 30; i++) tick;
    check("pre-reset tt", {16'd0, tt_a}, 32'h0000FC00);
    check("pre-reset busy", {31'd0, busy_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset tt", {16'd0, tt_a}, 32'd0);
    check("async reset flags",
          {26'd0, busy_a, done_a, ttv_a, match_a, unst_a, 1'b0}, 32'd0);
    check("async reset inputs", {28'd0, a_in1, a_in2, a_in3, a_in4}, 32'd0);
    tick; tick;
    rst_n = 1'b1;
    tick;
    kind_a = 0;
    run_sweep(1'b0, 16'h0068, 1'b0, lat);
    check_result("post reset", 1'b0, lat, 81, 16'h0068, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
